// File: rtl/prince_inv_sbox_layer_masked.sv
// Two-share masked PRINCE inverse S-box layer, one nibble per cycle.
// Ports: clk/rst_n, in_* input handshake+shares, rand_in/rand_req, out_* result.
module prince_inv_sbox_layer_masked #(
   parameter int NIBBLES = 16,
   parameter int RAND_W  = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_share1,
   input  logic [63:0]       in_share2,
   input  logic [RAND_W-1:0] rand_in,
   output logic              rand_req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_share1,
   output logic [63:0]       out_share2
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   function automatic logic [3:0] sinv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hB;
         4'h1: y = 4'h7;
         4'h2: y = 4'h3;
         4'h3: y = 4'h2;
         4'h4: y = 4'hF;
         4'h5: y = 4'hD;
         4'h6: y = 4'h8;
         4'h7: y = 4'h9;
         4'h8: y = 4'hA;
         4'h9: y = 4'h6;
         4'hA: y = 4'h4;
         4'hB: y = 4'h0;
         4'hC: y = 4'h5;
         4'hD: y = 4'hE;
         4'hE: y = 4'hC;
         default: y = 4'h1;
      endcase
      return y;
   endfunction

   // Algebraic normal form of one output bit (Moebius transform of its
   // truth table); bit u is the coefficient of monomial prod_{i in u} x_i.
   function automatic logic [15:0] anf_bit(input int j);
      logic [15:0] c;
      logic [3:0]  v;
      for (int u = 0; u < 16; u++) begin
         v    = sinv(4'(u));
         c[u] = v[j];
      end
      for (int i = 0; i < 4; i++) begin
         for (int u = 0; u < 16; u++) begin
            if (((u >> i) & 1) == 1) begin
               c[u] = c[u] ^ c[u ^ (1 << i)];
            end
         end
      end
      return c;
   endfunction

   localparam logic [3:0][15:0] ANF = {
      anf_bit(3), anf_bit(2), anf_bit(1), anf_bit(0)
   };

   // Coefficient multiplying monomial a^T when expanding f(a ^ b):
   // XOR over ANF terms U containing T of prod_{i in U\T} b_i.
   function automatic logic gterm(
      input int         j,
      input int         t,
      input logic [3:0] b
   );
      logic       g;
      logic [3:0] tt;
      logic [3:0] uu;
      g  = 1'b0;
      tt = 4'(t);
      for (int u = 0; u < 16; u++) begin
         uu = 4'(u);
         if (((uu & tt) == tt) && ANF[j][u]) begin
            g = g ^ (&(b | ~(uu & ~tt)));
         end
      end
      return g;
   endfunction

   state_t       r_state;
   logic [3:0]   r_cnt;
   logic [63:0]  r_sh1;
   logic [63:0]  r_sh2;
   logic [63:0]  r_out1;
   logic [63:0]  r_out2;
   logic [14:1]  r_m0;
   logic [14:1]  r_m1;
   logic [3:0]   r_b;
   logic         r_cvld;
   logic [3:0]   r_cidx;

   logic [3:0]   w_rm;
   logic [3:0]   w_a;
   logic [3:0]   w_b;
   logic [14:1]  w_m0;
   logic [14:1]  w_m1;
   logic [3:0]   w_y1;
   logic [3:0]   w_y2;
   logic         w_g;

   // The same fresh mask refreshes both shares, so their XOR is unchanged
   // while each share path only ever sees its own input share.
   assign w_rm = rand_in[17:14];
   assign w_a  = r_sh1[3:0] ^ w_rm;
   assign w_b  = r_sh2[3:0] ^ w_rm;

   // Stage 0: monomials of share 1 (index = variable subset), each split
   // into two shares with one fresh random bit.
   always_comb begin
      w_m0 = '0;
      w_m1 = '0;
      for (int t = 1; t < 15; t++) begin
         w_m1[t] = rand_in[t-1];
         w_m0[t] = (&(w_a | ~4'(t))) ^ rand_in[t-1];
      end
   end

   // Stage 1: f(a^b) = f(b) ^ XOR_T a^T * g_T(b); each monomial share
   // contributes to its own output share.
   always_comb begin
      w_y1 = '0;
      w_y2 = sinv(r_b);
      w_g  = 1'b0;
      for (int j = 0; j < 4; j++) begin
         for (int t = 1; t < 15; t++) begin
            w_g     = gterm(j, t, r_b);
            w_y1[j] = w_y1[j] ^ (r_m0[t] & w_g);
            w_y2[j] = w_y2[j] ^ (r_m1[t] & w_g);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_sh1   <= '0;
         r_sh2   <= '0;
         r_out1  <= '0;
         r_out2  <= '0;
         r_m0    <= '0;
         r_m1    <= '0;
         r_b     <= '0;
         r_cvld  <= 1'b0;
         r_cidx  <= '0;
      end else begin
         r_cvld <= 1'b0;
         if (r_cvld) begin
            r_out1[{r_cidx, 2'b00} +: 4] <= w_y1;
            r_out2[{r_cidx, 2'b00} +: 4] <= w_y2;
         end
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sh1   <= in_share1;
                  r_sh2   <= in_share2;
                  r_cnt   <= '0;
                  r_out1  <= '0;
                  r_out2  <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_m0   <= w_m0;
               r_m1   <= w_m1;
               r_b    <= w_b;
               r_cvld <= 1'b1;
               r_cidx <= r_cnt;
               r_sh1  <= r_sh1 >> 4;
               r_sh2  <= r_sh2 >> 4;
               r_cnt  <= r_cnt + 4'd1;
               if (r_cnt == 4'(NIBBLES - 1)) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_sh1   <= '0;
               r_sh2   <= '0;
               r_m0    <= '0;
               r_m1    <= '0;
               r_b     <= '0;
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = (r_state == S_IDLE);
   assign rand_req   = (r_state == S_RUN);
   assign out_valid  = (r_state == S_DONE);
   assign out_share1 = r_out1;
   assign out_share2 = r_out2;

endmodule
